hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Parametrised successor to the 5-stage pipeline hazard unit. Generalises forwarding to
//  NUM_SRC source operands per instruction. Adds a multi-cycle data-memory wait FSM
//  with timeout, and centralises all stall/flush generation for the F/D/E/M/W pipeline.
//  Sits beside the datapath in the cpu top; consumes register tags, writes back per-stage stall/flush.
// PARAMETERS
//  NUM_SRC      3   source operands tracked per instruction (Rn, Rm, Rs)
//  REG_W        4   register tag width
//  PC_REG       15  tag of PC; never forwarded, never load-use matched
//  MEM_TIMEOUT  255 max consecutive wait cycles before mem_err (counter width = $clog2(MEM_TIMEOUT+1))
// PORTS
//  clk            in  1              pipeline clock
//  reset          in  1              synchronous, active-low (0 = reset)
//  src_reg_d      in  NUM_SRC*REG_W  Decode source tags, operand i at [i*REG_W +: REG_W]
//  src_used_d     in  NUM_SRC        Decode operand i actually read
//  src_reg_e      in  NUM_SRC*REG_W  Execute source tags
//  src_used_e     in  NUM_SRC        Execute operand i actually read
//  dst_reg_e/m/w  in  REG_W each     destination tag in E, M, W
//  reg_write_e/m/w in 1 each         stage writes register file
//  mem_to_reg_e   in  1              E instruction is a load
//  mem_access_m   in  1              M instruction accesses data memory
//  mem_ready_m    in  1              data memory completes this cycle
//  branch_taken_e in  1              branch resolved taken in E
//  pc_src_d/e/m/w in  1 each         instruction in stage writes PC
//  forward_e      out NUM_SRC*2      per operand: 00 regfile, 01 from W, 10 from M
//  stall_f/d/e/m  out 1 each         hold stage register
//  flush_d/e/w    out 1 each         clear stage register to bubble
//  mem_err        out 1              sticky memory-timeout flag
// BEHAVIOUR
//  Reset (reset==0 at posedge): state<=RUN, wait_cnt<=0, mem_err<=0. While reset low,
//   stalls=0, flush_d=flush_e=flush_w=1, forward_e=0.
//  Forwarding (comb, per operand i): M if reg_write_m & src_used_e[i] & tag==dst_reg_m &
//   tag!=PC_REG; else W under same rule with W fields; else 00. M wins over W.
//  Load-use (comb): ld_stall = mem_to_reg_e & any_i(src_used_d[i] & src_reg_d[i]==dst_reg_e
//   & dst_reg_e!=PC_REG). Gives stall_f, stall_d, flush_e; resolves in exactly 1 bubble.
//  PC pending: pend = pc_src_d|pc_src_e|pc_src_m -> stall_f, flush_d. pc_src_w -> flush_d,
//   stall_f released in the same cycle so the new PC is fetched.
//  Branch: branch_taken_e -> flush_d, flush_e; zero extra stall.
//  Memory FSM: RUN -> WAIT when mem_access_m & !mem_ready_m. WAIT -> RUN on mem_ready_m.
//   In WAIT (and the RUN cycle that enters it): stall_f/d/e/m=1, flush_w=1; all other
//   flushes forced 0. Memory wait dominates; branch/load-use/PC-pend are re-evaluated on
//   the release cycle.
//  Wait counter: wait_cnt increments each WAIT cycle, saturates at MEM_TIMEOUT and
//   clears on RUN. At MEM_TIMEOUT: mem_err<=1 (sticky until reset), FSM -> RUN and the
//   access is dropped (flush_w the following cycle).
//  Simultaneous ld_stall & branch_taken_e: flush_e once, stall_f/d hold, flush_d applied.
//   Net: branch wins, no duplicate bubble.
//  Reset mid-WAIT: FSM returns to RUN on the next edge; the in-flight access is abandoned.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs stall_cnt, flush_cnt, mem_wait_cnt (32 b each,
//   wrap at 2^32, reset 0), counting cycles with stall_f, with any flush, and in WAIT.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  hazard_pkg: fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10), mem_state_t
//   enum (RUN, WAIT), PC_REG default constant.
//  Sub-module fwd_match (one tag vs M/W comparator plus select), generated NUM_SRC times.
// TESTING
//  1 ADD r1 in M, SUB reads r1 as src0 in E -> forward_e[1:0]=10; same r1 also in W -> still 10.
//  2 LDR r2 in E, Decode src1=r2 used -> stall_f=stall_d=flush_e=1 for 1 cycle, then forward_e=01.
//  3 Decode src reads r15 while M writes r15 -> forward_e=00, no ld_stall.
//  4 mem_access_m, mem_ready_m low 3 cycles -> stall_f..m and flush_w high 4 cycles total, WAIT 3 cycles.
//  5 MEM_TIMEOUT=4, mem_ready_m never -> mem_err=1 after 4 WAIT cycles, FSM RUN, held until reset=0.
//  6 branch_taken_e with ld_stall same cycle -> flush_d=flush_e=1 once; drop reset mid-WAIT -> RUN next edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_t   : per-operand forwarding select (regfile / W / M)
//   mem_state_t : data-memory wait FSM state
//   PC_REG_DEFAULT : register tag that aliases the PC
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam int unsigned PC_REG_DEFAULT = 15;

endpackage

// File: rtl/fwd_match.sv
// Single-operand forwarding comparator for the Execute stage.
// Compares one source tag against the M and W destination tags and picks the
// youngest producer. The PC tag is never forwarded.
// Ports:
//   src_reg      in  REG_W  Execute source tag
//   src_used     in  1      operand is actually read
//   dst_reg_m    in  REG_W  destination tag in Memory
//   reg_write_m  in  1      Memory instruction writes the register file
//   dst_reg_w    in  REG_W  destination tag in Writeback
//   reg_write_w  in  1      Writeback instruction writes the register file
//   fwd_sel      out 2      FWD_RF / FWD_W / FWD_M
module fwd_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W  = 4,
  parameter int unsigned PC_REG = PC_REG_DEFAULT
) (
  input  logic [REG_W-1:0] src_reg,
  input  logic             src_used,
  input  logic [REG_W-1:0] dst_reg_m,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] dst_reg_w,
  input  logic             reg_write_w,
  output fwd_sel_t         fwd_sel
);

  logic not_pc;
  logic hit_m;
  logic hit_w;

  assign not_pc = (src_reg != REG_W'(PC_REG));
  assign hit_m  = reg_write_m & src_used & not_pc & (src_reg == dst_reg_m);
  assign hit_w  = reg_write_w & src_used & not_pc & (src_reg == dst_reg_w);

  // M holds the younger result, so it takes priority over W.
  always_comb begin
    fwd_sel = FWD_RF;
    if (hit_m) begin
      fwd_sel = FWD_M;
    end else if (hit_w) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the F/D/E/M/W pipeline: operand forwarding into
// Execute, load-use interlock, PC-write and branch flushes, and a multi-cycle
// data-memory wait FSM with a timeout that raises a sticky error flag.
// Optional build macro HAZARD_PERF_EN adds 32-bit performance counters.
// Ports:
//   clk, reset                  clock; synchronous reset, active low
//   src_reg_d/src_used_d        Decode source tags / operand-read flags
//   src_reg_e/src_used_e        Execute source tags / operand-read flags
//   dst_reg_e/m/w, reg_write_*  destination tags and write enables per stage
//   mem_to_reg_e                Execute instruction is a load
//   mem_access_m, mem_ready_m   Memory-stage access request / completion
//   branch_taken_e              branch resolved taken in Execute
//   pc_src_d/e/m/w              stage instruction writes the PC
//   forward_e                   2-bit forwarding select per operand
//   stall_f/d/e/m               hold stage register
//   flush_d/e/w                 turn stage register into a bubble
//   mem_err                     sticky memory-timeout flag
//   stall_cnt, flush_cnt, mem_wait_cnt  (HAZARD_PERF_EN only) cycle counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 3,
  parameter int unsigned REG_W       = 4,
  parameter int unsigned PC_REG      = PC_REG_DEFAULT,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*REG_W-1:0] src_reg_d,
  input  logic [NUM_SRC-1:0]       src_used_d,
  input  logic [NUM_SRC*REG_W-1:0] src_reg_e,
  input  logic [NUM_SRC-1:0]       src_used_e,
  input  logic [REG_W-1:0]         dst_reg_e,
  input  logic [REG_W-1:0]         dst_reg_m,
  input  logic [REG_W-1:0]         dst_reg_w,
  input  logic                     reg_write_e,
  input  logic                     reg_write_m,
  input  logic                     reg_write_w,
  input  logic                     mem_to_reg_e,
  input  logic                     mem_access_m,
  input  logic                     mem_ready_m,
  input  logic                     branch_taken_e,
  input  logic                     pc_src_d,
  input  logic                     pc_src_e,
  input  logic                     pc_src_m,
  input  logic                     pc_src_w,
  output logic [NUM_SRC*2-1:0]     forward_e,
  output logic                     stall_f,
  output logic                     stall_d,
  output logic                     stall_e,
  output logic                     stall_m,
  output logic                     flush_d,
  output logic                     flush_e,
  output logic                     flush_w,
  output logic                     mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              flush_cnt,
  output logic [31:0]              mem_wait_cnt
`endif
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  fwd_sel_t             fwd_sel [NUM_SRC];
  logic [NUM_SRC*2-1:0] fwd_raw;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_match #(
      .REG_W (REG_W),
      .PC_REG(PC_REG)
    ) u_fwd_match (
      .src_reg    (src_reg_e[i*REG_W +: REG_W]),
      .src_used   (src_used_e[i]),
      .dst_reg_m  (dst_reg_m),
      .reg_write_m(reg_write_m),
      .dst_reg_w  (dst_reg_w),
      .reg_write_w(reg_write_w),
      .fwd_sel    (fwd_sel[i])
    );
    assign fwd_raw[i*2 +: 2] = fwd_sel[i];
  end

  // ---------------------------------------------------------------------------
  // Load-use interlock
  // ---------------------------------------------------------------------------
  logic ld_hit;
  logic ld_stall;

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      ld_hit = ld_hit | (src_used_d[i] & (src_reg_d[i*REG_W +: REG_W] == dst_reg_e));
    end
  end

  assign ld_stall = mem_to_reg_e & ld_hit & (dst_reg_e != REG_W'(PC_REG));

  // reg_write_e is informational only; loads are identified by mem_to_reg_e.
  logic unused_rw_e;
  assign unused_rw_e = reg_write_e;

  // ---------------------------------------------------------------------------
  // Memory wait FSM
  // ---------------------------------------------------------------------------
  mem_state_t      state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;
  // One-cycle marker after a timeout: the abandoned access must not re-enter
  // WAIT, and its writeback is squashed.
  logic            drop_q, drop_d;
  logic            mem_miss;
  logic            mem_stall;

  assign mem_miss  = mem_access_m & ~mem_ready_m & ~drop_q;
  assign mem_stall = (state_q == WAIT) | mem_miss;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    drop_d     = 1'b0;
    case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (mem_miss) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_ready_m) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CntW'(MEM_TIMEOUT - 1)) begin
          // Saturate; the RUN state clears the counter on the next cycle.
          state_d    = RUN;
          wait_cnt_d = CntW'(MEM_TIMEOUT);
          mem_err_d  = 1'b1;
          drop_d     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      drop_q     <= drop_d;
    end
  end

  assign mem_err = mem_err_q;

  // ---------------------------------------------------------------------------
  // Stall / flush generation
  // ---------------------------------------------------------------------------
  logic pc_pend;
  assign pc_pend = pc_src_d | pc_src_e | pc_src_m;

  always_comb begin
    forward_e = '0;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;
    if (!reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_stall) begin
      // Whole pipe frozen behind M; W receives bubbles. Other hazards are
      // re-evaluated once the memory releases.
      forward_e = fwd_raw;
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_e   = 1'b1;
      stall_m   = 1'b1;
      flush_w   = 1'b1;
    end else begin
      forward_e = fwd_raw;
      stall_f   = ld_stall | pc_pend;
      stall_d   = ld_stall;
      flush_d   = pc_pend | pc_src_w | branch_taken_e;
      flush_e   = ld_stall | branch_taken_e;
      flush_w   = drop_q;
    end
  end

`ifdef HAZARD_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (wrap naturally at 2^32)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      mem_wait_cnt <= '0;
    end else begin
      stall_cnt    <= stall_cnt + {31'd0, stall_f};
      flush_cnt    <= flush_cnt + {31'd0, (flush_d | flush_e | flush_w)};
      mem_wait_cnt <= mem_wait_cnt + {31'd0, (state_q == WAIT)};
    end
  end
`endif

endmodule
